ram_read_streamer: RTL
======================

# ram_read_streamer

Read-side sequencer placed directly downstream of a `ram` instance built with OUTPUT_REG=1 or 0. It accepts a burst descriptor (base address, stride, beat count) and issues one read per cycle into the RAM read port. It captures the returned words and presents them as a valid/ready stream with a last flag. Backpressure is absorbed by a 2-entry buffer, so the RAM is never read faster than the consumer can drain.

## Interface
- DATA_WIDTH, 10, word width; matches the RAM.
- ADDR_WIDTH, 12, RAM address width.
- COUNT_WIDTH, 16, width of the beat-count field.
- RAM_LATENCY, 1, read latency of the attached RAM in cycles. Legal values: 0 or 1. Must equal the RAM's OUTPUT_REG.
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- cfg_start  in  1  start pulse; sampled only in IDLE.
- cfg_base_addr  in  ADDR_WIDTH  first read address.
- cfg_stride  in  ADDR_WIDTH  address increment per beat.
- cfg_count  in  COUNT_WIDTH  number of beats.
- busy  out  1  high from the cycle after accepted start until done.
- done  out  1  one-cycle pulse at burst completion.
- mem_read_req  out  1  RAM read enable.
- mem_read_addr  out  ADDR_WIDTH  RAM read address.
- mem_read_data  in  DATA_WIDTH  RAM read data.
- m_data  out  DATA_WIDTH  stream data.
- m_valid  out  1  stream valid.
- m_ready  in  1  stream ready.
- m_last  out  1  marks the final beat of the burst.

## Operation
- FSM states:
  - IDLE: cfg_start=1 latches base, stride and count.
    - count=0: go to DONE.
    - otherwise: go to RUN.
  - RUN: issues reads. After the final read has been issued, go to DRAIN.
  - DRAIN: waits until the buffer is empty and no read is in flight, then goes to DONE.
  - DONE: asserts done for one cycle, then returns to IDLE.
- busy = (state != IDLE). cfg_start is ignored while busy.
- Address generation:
  - First read address = base.
  - Each next address = previous address + stride, modulo 2^ADDR_WIDTH (wrap-around is silent).
- Issue rule: mem_read_req = RUN && (occupancy + inflight − pop) < 2, where pop = m_valid && m_ready in the current cycle.
  - This sustains 1 beat/cycle while m_ready is held high.
  - The buffer can never overflow.
- Data capture:
  - RAM_LATENCY=1: mem_read_data is captured one cycle after its mem_read_req.
  - RAM_LATENCY=0: mem_read_data is captured in the same cycle as its mem_read_req.
- Captured data is pushed into the buffer. m_data, m_valid and m_last come from the buffer head.
- m_last is attached to the beat whose issue index equals count−1.
- A beat is transferred when m_valid && m_ready are high together. m_data and m_last must stay stable while m_valid=1 and m_ready=0.
- Reset mid-burst: state returns to IDLE; counters, buffer and in-flight tracking are cleared. Returned data arriving afterwards is discarded.
- Counters are COUNT_WIDTH wide. The remaining-beats counter decrements per issue.

## Timing
- Reset values: busy=0, done=0, mem_read_req=0, mem_read_addr=0, m_valid=0, m_last=0, m_data=0.
- Start sampled at edge E0. State is RUN in the cycle after E0, and the first mem_read_req is asserted in that cycle (cycle 1).
- First m_valid:
  - RAM_LATENCY=1: cycle 3.
  - RAM_LATENCY=0: cycle 2.
- With m_ready held at 1, beats are back-to-back.
- Burst of N beats, RAM_LATENCY=1, no stalls:
  - last handshake in cycle N+2;
  - done pulses in cycle N+3;
  - busy deasserts in cycle N+4.
- count=0: done pulses in the cycle after E0. No mem_read_req and no m_valid occur.
- Only combinational path input→output: m_ready → mem_read_req.

## Structure
- Package ram_stream_pkg contains:
  - the state enum (IDLE, RUN, DRAIN, DONE);
  - the constant BUF_DEPTH=2.
- Sub-module stream_skid_fifo provides:
  - a 2-entry buffer of width DATA_WIDTH+1 (the extra bit carries last);
  - push, pop and occupancy outputs;
  - a synchronous reset that clears the buffer.
- The top level holds the FSM, address/count generation and the in-flight register.

## Test plan
- Burst base=0x010, stride=1, count=4, m_ready=1, RAM preloaded mem[a]=a:
  - reads issued at 0x010–0x013 in consecutive cycles;
  - m_data = 0x010..0x013 in consecutive cycles, m_last only on 0x013;
  - done pulses once.
- Address wrap: base=0xFFE, stride=3, count=3 → read addresses 0xFFE, 0x001, 0x004.
- Backpressure: count=8, m_ready toggled 1,0,0,1,…:
  - no beat is lost or duplicated;
  - m_data is stable while stalled;
  - at no point do buffered plus in-flight reads exceed 2.
- count=0 → done pulses in the cycle after start; zero reads; m_valid never asserted.
- Reset asserted during RUN at beat 2 of 6:
  - all outputs return to reset values in the next cycle;
  - a new burst started afterwards streams correctly with no stale data.
- cfg_start pulsed while busy → ignored: the beat count and addresses of the current burst are unchanged. Repeat with RAM_LATENCY=0.

Source files
------------

// File: rtl/ram_stream_pkg.sv
// Shared state encoding and buffer sizing for the RAM read streamer.
package ram_stream_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    localparam int BUF_DEPTH = 2;
    localparam int OCC_WIDTH = $clog2(BUF_DEPTH + 1);

endpackage

// File: rtl/stream_skid_fifo.sv
// Two-entry buffer; entry 0 is always the head, so the head only moves on a pop.
module stream_skid_fifo
    import ram_stream_pkg::*;
#(
    parameter int WIDTH = 11
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push,
    input  logic [WIDTH-1:0]     push_data,
    input  logic                 pop,
    output logic [WIDTH-1:0]     head_data,
    output logic                 head_valid,
    output logic [OCC_WIDTH-1:0] occupancy
);

    logic [WIDTH-1:0]     slot0;
    logic [WIDTH-1:0]     slot1;
    logic [OCC_WIDTH-1:0] count;
    logic                 do_pop;
    logic                 do_push;

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != OCC_WIDTH'(BUF_DEPTH)) || do_pop);

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        // NOTE: both entries are cleared too, so the head reads zero after reset instead of stale data.
        if (reset) begin
            slot0 <= '0;
            slot1 <= '0;
            count <= '0;
        end else begin
            case ({do_push, do_pop})
                2'b10: begin
                    if (count == '0) slot0 <= push_data;
                    else             slot1 <= push_data;
                    count <= count + OCC_WIDTH'(1);
                end
                2'b01: begin
                    slot0 <= slot1;
                    count <= count - OCC_WIDTH'(1);
                end
                2'b11: begin
                    if (count == OCC_WIDTH'(1)) begin
                        slot0 <= push_data;
                    end else begin
                        slot0 <= slot1;
                        slot1 <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign head_data  = slot0;
    assign head_valid = (count != '0);
    assign occupancy  = count;

endmodule

// File: rtl/ram_read_streamer.sv
// Burst read sequencer: walks base/stride addresses into a RAM read port and
// streams the returned words out with valid/ready and a last flag.
module ram_read_streamer
    import ram_stream_pkg::*;
#(
    parameter int DATA_WIDTH  = 10,
    parameter int ADDR_WIDTH  = 12,
    parameter int COUNT_WIDTH = 16,
    parameter int RAM_LATENCY = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cfg_start,
    input  logic [ADDR_WIDTH-1:0]  cfg_base_addr,
    input  logic [ADDR_WIDTH-1:0]  cfg_stride,
    input  logic [COUNT_WIDTH-1:0] cfg_count,
    output logic                   busy,
    output logic                   done,
    output logic                   mem_read_req,
    output logic [ADDR_WIDTH-1:0]  mem_read_addr,
    input  logic [DATA_WIDTH-1:0]  mem_read_data,
    output logic [DATA_WIDTH-1:0]  m_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic                   m_last
);

    localparam int PEND_WIDTH = OCC_WIDTH + 1;

    state_t                 state;
    state_t                 state_next;
    logic [ADDR_WIDTH-1:0]  addr;
    logic [ADDR_WIDTH-1:0]  stride;
    logic [COUNT_WIDTH-1:0] remaining;
    logic                   inflight;
    logic                   inflight_last;
    logic [OCC_WIDTH-1:0]   occupancy;
    logic [PEND_WIDTH-1:0]  pending;
    logic                   pop;
    logic                   push;
    logic                   push_last;
    logic                   issue_last;
    logic [DATA_WIDTH:0]    head;

    // Reads are only issued when a buffer slot is guaranteed for the returning word.
    assign pop          = m_valid && m_ready;
    assign pending      = PEND_WIDTH'(occupancy) + PEND_WIDTH'(inflight) - PEND_WIDTH'(pop);
    assign issue_last   = (remaining == COUNT_WIDTH'(1));
    assign mem_read_req = (state == RUN) && (pending < PEND_WIDTH'(BUF_DEPTH));
    assign mem_read_addr = addr;

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    assign push      = (RAM_LATENCY == 0) ? mem_read_req : inflight;
    assign push_last = (RAM_LATENCY == 0) ? issue_last   : inflight_last;

    always_comb begin
        // NOTE: default first so every path assigns state_next and no latch is inferred.
        state_next = state;
        case (state)
            IDLE:    if (cfg_start) state_next = (cfg_count == '0) ? DONE : RUN;
            RUN:     if (mem_read_req && issue_last) state_next = DRAIN;
            // Leave as soon as the buffer empties this cycle, so done follows the last handshake directly.
            DRAIN:   if (!inflight && (occupancy == OCC_WIDTH'(pop))) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            addr          <= '0;
            stride        <= '0;
            remaining     <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            state <= state_next;
            if (state == IDLE && cfg_start) begin
                addr      <= cfg_base_addr;
                stride    <= cfg_stride;
                remaining <= cfg_count;
            end else if (mem_read_req) begin
                addr      <= addr + stride;
                remaining <= remaining - COUNT_WIDTH'(1);
            end
            inflight      <= (RAM_LATENCY == 1) && mem_read_req;
            inflight_last <= issue_last;
        end
    end

    stream_skid_fifo #(
        .WIDTH(DATA_WIDTH + 1)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data ({push_last, mem_read_data}),
        .pop       (pop),
        .head_data (head),
        .head_valid(m_valid),
        .occupancy (occupancy)
    );

    assign m_data = head[DATA_WIDTH-1:0];
    assign m_last = head[DATA_WIDTH];

endmodule
